// File: rtl/neuron_weight_mult_pkg.sv
// ---------------------------------------------------------------------------
// neuron_weight_mult_pkg
// Shared types and helpers for the neuron_weight_mult block.
//   state_t   : control FSM states (IDLE, MULTIPLY, DRAIN, DONE)
//   cnt_width : width of a counter that must be able to hold 0..num_inputs
// ---------------------------------------------------------------------------
package neuron_weight_mult_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MULTIPLY = 2'd1,
      DRAIN    = 2'd2,
      DONE     = 2'd3
   } state_t;

   // Counters run up to num_inputs inclusive, hence the +1.
   function automatic int cnt_width(input int num_inputs);
      return $clog2(num_inputs + 1);
   endfunction

endpackage

// File: rtl/neuron_weight_mult_mul.sv
// ---------------------------------------------------------------------------
// fixed_point_mul
// Registered signed WIDTH x WIDTH multiplier with a one-cycle valid pipe.
// Scaling and width reduction are left to the caller.
// Ports:
//   CLK           : clock, rising edge
//   RSTN          : synchronous active-low reset
//   op_a, op_b    : signed operands
//   op_valid      : operands are valid this cycle
//   product       : registered full-width signed product (2*WIDTH bits)
//   product_valid : high for one cycle per accepted operand pair
// ---------------------------------------------------------------------------
module fixed_point_mul
   import neuron_weight_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                      CLK,
   input  logic                      RSTN,
   input  logic signed [WIDTH-1:0]   op_a,
   input  logic signed [WIDTH-1:0]   op_b,
   input  logic                      op_valid,
   output logic signed [2*WIDTH-1:0] product,
   output logic                      product_valid
);

   logic signed [2*WIDTH-1:0] product_reg;
   logic                      product_valid_reg;

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         product_reg       <= '0;
         product_valid_reg <= 1'b0;
      end else begin
         product_valid_reg <= op_valid;
         if (op_valid) begin
            // Both operands are signed, so they are sign-extended to the
            // 2*WIDTH context before multiplying.
            product_reg <= op_a * op_b;
         end
      end
   end

   assign product       = product_reg;
   assign product_valid = product_valid_reg;

endmodule

// File: rtl/neuron_weight_mult.sv
// ---------------------------------------------------------------------------
// neuron_weight_mult
// Multiplies a vector of activations by a vector of weights element-wise
// through one shared registered multiplier, rescales each product by
// FRAC_BITS and publishes the whole result vector at once.
//
// Parameters:
//   WIDTH      : operand/product width (signed), default 8
//   FRAC_BITS  : fractional bits, 0 < FRAC_BITS < WIDTH, default 3
//   NUM_INPUTS : vector length, >= 2, default 16
// Ports:
//   CLK          : clock, rising edge
//   RSTN         : synchronous active-low reset
//   VALUES_IN    : signed activations, captured when a request is accepted
//   WEIGHTS_IN   : signed weights, captured together with VALUES_IN
//   VALID_IN     : request, only sampled while idle
//   PRODUCTS_OUT : result vector, held between completions
//   VALID_OUT    : one-cycle pulse when PRODUCTS_OUT is refreshed
//   BUSY_OUT     : high whenever the FSM is not idle
// Build option:
//   SATURATION_EN : when defined, rescaled products clamp to the signed
//                   WIDTH range; otherwise the low WIDTH bits are kept.
//
// Timing (E0 = accepting edge): issues at E1..EN, writebacks at
// E2..E(N+1), PRODUCTS_OUT/VALID_OUT at E(N+2).
// ---------------------------------------------------------------------------
module neuron_weight_mult
   import neuron_weight_mult_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int FRAC_BITS  = 3,
   parameter int NUM_INPUTS = 16
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   input  logic signed [WIDTH-1:0] VALUES_IN    [NUM_INPUTS],
   input  logic signed [WIDTH-1:0] WEIGHTS_IN   [NUM_INPUTS],
   input  logic                    VALID_IN,
   output logic signed [WIDTH-1:0] PRODUCTS_OUT [NUM_INPUTS],
   output logic                    VALID_OUT,
   output logic                    BUSY_OUT
);

   localparam int CW = cnt_width(NUM_INPUTS);
   localparam int IW = $clog2(NUM_INPUTS);

   state_t                    state_reg;
   logic [CW-1:0]             issue_cnt_reg;
   logic [CW-1:0]             wb_cnt_reg;
   logic [CW-1:0]             wb_cnt_next;
   logic                      valid_out_reg;

   logic                      accept;
   logic                      in_done;
   logic                      mul_valid;
   logic [IW-1:0]             issue_idx;
   logic [IW-1:0]             wb_idx;
   logic signed [WIDTH-1:0]   mul_a;
   logic signed [WIDTH-1:0]   mul_b;
   logic signed [2*WIDTH-1:0] product;
   logic                      product_valid;
   logic signed [2*WIDTH-1:0] scaled;
   logic signed [WIDTH-1:0]   reduced;

   logic signed [WIDTH-1:0]   value_bus  [NUM_INPUTS];
   logic signed [WIDTH-1:0]   weight_bus [NUM_INPUTS];

   assign accept    = (state_reg == IDLE) && VALID_IN;
   assign in_done   = (state_reg == DONE);
   assign mul_valid = (state_reg == MULTIPLY);
   assign BUSY_OUT  = (state_reg != IDLE);
   assign VALID_OUT = valid_out_reg;

   // Counters never index past NUM_INPUTS-1 while they are used as
   // indices, so the low IW bits are sufficient.
   assign issue_idx   = issue_cnt_reg[IW-1:0];
   assign wb_idx      = wb_cnt_reg[IW-1:0];
   assign wb_cnt_next = wb_cnt_reg + CW'(product_valid);

   assign mul_a = value_bus[issue_idx];
   assign mul_b = weight_bus[issue_idx];

   fixed_point_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .CLK           (CLK),
      .RSTN          (RSTN),
      .op_a          (mul_a),
      .op_b          (mul_b),
      .op_valid      (mul_valid),
      .product       (product),
      .product_valid (product_valid)
   );

   // Arithmetic shift: rounds toward minus infinity.
   assign scaled = product >>> FRAC_BITS;

`ifdef SATURATION_EN
   localparam logic signed [2*WIDTH-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [2*WIDTH-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   always_comb begin
      reduced = scaled[WIDTH-1:0];
      if (scaled > SAT_MAX) begin
         reduced = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (scaled < SAT_MIN) begin
         reduced = {1'b1, {(WIDTH-1){1'b0}}};
      end
   end
`else
   // Two's-complement wrap: keep only the low WIDTH bits.
   assign reduced = WIDTH'(scaled);
`endif

   // Control FSM. DRAIN looks at the counter value after this cycle's
   // writeback so DONE is entered on the same edge as the last writeback,
   // which lets PRODUCTS_OUT update exactly N+2 edges after acceptance.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_reg     <= IDLE;
         issue_cnt_reg <= '0;
         wb_cnt_reg    <= '0;
         valid_out_reg <= 1'b0;
      end else begin
         valid_out_reg <= 1'b0;
         if (product_valid) begin
            wb_cnt_reg <= wb_cnt_next;
         end
         case (state_reg)
            IDLE: begin
               if (VALID_IN) begin
                  issue_cnt_reg <= '0;
                  wb_cnt_reg    <= '0;
                  state_reg     <= MULTIPLY;
               end
            end
            MULTIPLY: begin
               issue_cnt_reg <= issue_cnt_reg + CW'(1);
               if (issue_cnt_reg == CW'(NUM_INPUTS - 1)) begin
                  state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               if (wb_cnt_next == CW'(NUM_INPUTS)) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               valid_out_reg <= 1'b1;
               state_reg     <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Per-lane storage: captured operands, the work array that collects
   // writebacks, and the published copy that downstream reads while the
   // next vector is being computed.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
         logic signed [WIDTH-1:0] value_reg;
         logic signed [WIDTH-1:0] weight_reg;
         logic signed [WIDTH-1:0] work_reg;
         logic signed [WIDTH-1:0] products_reg;

         always_ff @(posedge CLK) begin
            if (!RSTN) begin
               value_reg    <= '0;
               weight_reg   <= '0;
               work_reg     <= '0;
               products_reg <= '0;
            end else begin
               if (accept) begin
                  value_reg  <= VALUES_IN[gi];
                  weight_reg <= WEIGHTS_IN[gi];
               end
               if (product_valid && (wb_idx == IW'(gi))) begin
                  work_reg <= reduced;
               end
               if (in_done) begin
                  products_reg <= work_reg;
               end
            end
         end

         assign value_bus[gi]    = value_reg;
         assign weight_bus[gi]   = weight_reg;
         assign PRODUCTS_OUT[gi] = products_reg;
      end
   endgenerate

endmodule
